// File: rtl/fifo_rd_arbiter.sv
// Round-robin read-side arbiter draining NREQ FWFT command FIFOs into one registered stream.
// Optional macro ARB_PRIO0_EN: FIFO 0 gets strict priority over the round-robin order.
//
// state | meaning
// IDLE  | no grant; choose next non-empty FIFO after last-served index
// BUSY  | FIFO g granted; pop up to BURST words, release on empty or burst end
module fifo_rd_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [NREQ-1:0]       rempty,
  input  logic [NREQ*DSIZE-1:0] rdata,
  output logic [NREQ-1:0]       rinc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DSIZE-1:0]      out_data,
  output logic [SW-1:0]         out_src
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [SW-1:0] g;
  logic [SW-1:0] last;
  logic [SW-1:0] pick;
  logic [CW-1:0] cnt;
  logic          load;
  logic          prio_cut;
  logic          burst_end;

  // The pop is gated by reset so an in-flight grant never consumes a word during reset.
  always_comb begin
    load = (state == BUSY) && !rempty[g] && (!out_valid || out_ready) && !rrst;
  end

  always_comb begin
    rinc = '0;
    if (load) rinc[g] = 1'b1;
  end

  always_comb begin
    logic found;
    int   idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && !rempty[idx]) begin
        pick  = SW'(idx);
        found = 1'b1;
      end
    end
`ifdef ARB_PRIO0_EN
    if (!rempty[0]) pick = '0;
`endif
  end

`ifdef ARB_PRIO0_EN
  always_comb prio_cut = (g != '0) && !rempty[0];
`else
  always_comb prio_cut = 1'b0;
`endif

  always_comb burst_end = (cnt == CW'(BURST - 1)) || prio_cut;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state     <= IDLE;
      g         <= '0;
      cnt       <= '0;
      last      <= SW'(NREQ - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= rdata[g*DSIZE +: DSIZE];
        out_src   <= g;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!(&rempty)) begin
            g     <= pick;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (load) begin
            cnt <= cnt + 1'b1;
            if (burst_end) begin
              last  <= g;
              state <= IDLE;
            end
          end else if (rempty[g]) begin
            last  <= g;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: queue-based FWFT FIFO models, per-source scoreboard, directed steps.
module tb_fifo_rd_arbiter;

  logic        rclk = 1'b0;
  logic        rrst;
  logic [3:0]  rempty;
  logic [31:0] rdata;
  logic [3:0]  rinc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;

  logic [7:0]  fq    [4][$];
  logic [7:0]  exp_q [4][$];
  int          src_q [$];
  int          hs_q  [$];
  logic [3:0]  rinc_s = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic [1:0]  prev_src;

  fifo_rd_arbiter #(.NREQ(4), .DSIZE(8), .BURST(4)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      rempty[i]        = (fq[i].size() == 0);
      rdata[i*8 +: 8]  = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    fq[i].push_back(d);
    exp_q[i].push_back(d);
    refresh();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 4; i++)
      if (fq[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string tag, input int max);
    bit done = 1'b0;
    for (int c = 0; c < max && !done; c++) begin
      @(negedge rclk);
      if (!out_valid && all_empty()) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // FIFO read side: pop strobe seen late in the cycle takes effect just after the edge
  always @(negedge rclk) begin
    #3;
    rinc_s = rinc;
  end

  always @(posedge rclk) begin
    #1;
    for (int i = 0; i < 4; i++)
      if (rinc_s[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    refresh();
  end

  // Output monitor: scoreboard pops on every handshake
  always @(negedge rclk) begin
    #1;
    cyc++;
    if (rrst) begin
      prev_stall = 1'b0;
    end else begin
      chk("rinc_onehot", 32'($countones(rinc) <= 1), 32'd1);
      chk("rinc_on_empty", 32'(rinc & rempty), 32'd0);
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_src", 32'(out_src), 32'(prev_src));
      end
      if (out_valid && out_ready) begin
        hs_q.push_back(cyc);
        chk("word_pending", 32'(exp_q[out_src].size() > 0), 32'd1);
        if (exp_q[out_src].size() > 0)
          chk("out_data", 32'(out_data), 32'(exp_q[out_src].pop_front()));
        if (src_q.size() > 0)
          chk("out_src_order", 32'(out_src), 32'(src_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_src   = out_src;
    end
  end

  initial begin
    logic [7:0] held;
    int         nv;
    bit         seen;
    refresh();
    rrst      = 1'b1;
    out_ready = 1'b1;

    // Test 1: single FIFO 2 with A,B,C, exact cycle timing
    push(2, 8'hA1);
    push(2, 8'hB2);
    push(2, 8'hC3);
    @(negedge rclk);
    @(negedge rclk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);
    rrst = 1'b0;
    @(negedge rclk);
    chk("t1_c1_rinc", 32'(rinc), 32'h4);
    chk("t1_c1_valid", 32'(out_valid), 32'd0);
    @(negedge rclk);
    chk("t1_c2_rinc", 32'(rinc), 32'h4);
    chk("t1_c2_data", 32'(out_data), 32'hA1);
    chk("t1_c2_src", 32'(out_src), 32'd2);
    @(negedge rclk);
    chk("t1_c3_rinc", 32'(rinc), 32'h4);
    chk("t1_c3_data", 32'(out_data), 32'hB2);
    @(negedge rclk);
    chk("t1_c4_rinc", 32'(rinc), 32'h0);
    chk("t1_c4_data", 32'(out_data), 32'hC3);
    chk("t1_c4_valid", 32'(out_valid), 32'd1);
    @(negedge rclk);
    chk("t1_c5_valid", 32'(out_valid), 32'd0);
    wait_drain("t1_drain", 10);

    // Test 2: all four FIFOs hold six words, round-robin bursts of four
    rrst = 1'b1;
    @(negedge rclk);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 6; k++) push(i, 8'((i << 4) | k));
`ifdef ARB_PRIO0_EN
    for (int k = 0; k < 6; k++) src_q.push_back(0);
    for (int i = 1; i < 4; i++) for (int k = 0; k < 4; k++) src_q.push_back(i);
    for (int i = 1; i < 4; i++) for (int k = 0; k < 2; k++) src_q.push_back(i);
`else
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) src_q.push_back(i);
    for (int i = 0; i < 4; i++) for (int k = 0; k < 2; k++) src_q.push_back(i);
`endif
    hs_q.delete();
    @(negedge rclk);
    rrst = 1'b0;
    wait_drain("t2_drain", 80);
    chk("t2_words", 32'(hs_q.size()), 32'd24);
    chk("t2_src_seq_done", 32'(src_q.size()), 32'd0);
`ifndef ARB_PRIO0_EN
    if (hs_q.size() >= 16)
      chk("t2_span_4_bursts", 32'(hs_q[15] - hs_q[0]), 32'd18);
`endif

    // Test 3: five-cycle output stall in the middle of a burst
    for (int k = 0; k < 4; k++) push(1, 8'h10 | 8'(k));
    nv   = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge rclk);
      if (out_valid) begin
        nv++;
        if (nv == 2) begin
          out_ready = 1'b0;
          held      = out_data;
          seen      = 1'b1;
        end
      end
    end
    chk("t3_reached_stall", 32'(seen), 32'd1);
    chk("t3_held_word", 32'(held), 32'h11);
    for (int c = 0; c < 5; c++) begin
      @(negedge rclk);
      chk("t3_stall_valid", 32'(out_valid), 32'd1);
      chk("t3_stall_data", 32'(out_data), 32'(held));
      chk("t3_stall_rinc", 32'(rinc), 32'd0);
    end
    out_ready = 1'b1;
    wait_drain("t3_drain", 20);

    // Test 4: reset while busy with a word held in the output register
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(2, 8'h20 | 8'(k));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge rclk);
      if (out_valid) seen = 1'b1;
    end
    chk("t4_busy_valid", 32'(seen), 32'd1);
    rrst      = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t4_rinc_in_reset", 32'(rinc), 32'd0);
    void'(exp_q[2].pop_front());
    push(1, 8'h1A);
    push(3, 8'h3A);
    src_q.push_back(1);
    src_q.push_back(2);
    src_q.push_back(2);
    src_q.push_back(3);
    @(negedge rclk);
    chk("t4_valid_after_rst", 32'(out_valid), 32'd0);
    chk("t4_data_after_rst", 32'(out_data), 32'd0);
    rrst = 1'b0;
    wait_drain("t4_drain", 40);
    chk("t4_src_seq_done", 32'(src_q.size()), 32'd0);

    // Test 5: FIFO 0 becomes non-empty while FIFO 1 is bursting
    for (int k = 8; k < 13; k++) push(1, 8'h10 | 8'(k));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge rclk);
      if (rinc[1]) seen = 1'b1;
    end
    chk("t5_burst_started", 32'(seen), 32'd1);
    push(0, 8'h0F);
`ifdef ARB_PRIO0_EN
    src_q.push_back(1);
    src_q.push_back(0);
    for (int k = 0; k < 4; k++) src_q.push_back(1);
`else
    for (int k = 0; k < 4; k++) src_q.push_back(1);
    src_q.push_back(0);
    src_q.push_back(1);
`endif
    wait_drain("t5_drain", 40);
    chk("t5_src_seq_done", 32'(src_q.size()), 32'd0);

    @(negedge rclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
